bldc_commutator: RTL and testbench
==================================

# bldc_commutator

Six-step trapezoidal commutation stage for the brushless motor drive. It consumes the single-bit PWM produced by the PWM generator and the three Hall-sensor inputs. It drives the six gate signals of the 3-phase inverter, with complementary switching on the active leg, per-leg dead-time insertion and invalid-Hall fault shutdown. It sits directly downstream of the PWM generator and directly upstream of the gate-driver pins.

## Interface
- DEADTIME, 16: both-off gap, in clk cycles, between opposite switches of one leg (≥1).
- DEBOUNCE, 4: consecutive identical synchronised Hall samples required to accept a new Hall code (≥1).
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  drive enable; low forces all gates off and clears fault
- dir  input  1  0 = forward, 1 = reverse
- pwm_in  input  1  PWM from the PWM generator
- hall  input  3  raw Hall sensors {C,B,A}, asynchronous
- gate_h  output  3  high-side gates {C,B,A}
- gate_l  output  3  low-side gates {C,B,A}
- sector  output  3  current sector 0–5; 7 = none/invalid
- commutate  output  1  one-cycle pulse on every accepted sector change
- fault  output  1  sticky invalid-Hall fault

## Operation
- Hall path: 2-flop synchroniser, then debounce counter. The debounced code updates after DEBOUNCE consecutive equal samples. hall_valid stays 0 from reset until the first accepted code.
- Decode: 001→0, 011→1, 010→2, 110→3, 100→4, 101→5.
- 000/111 accepted while enable=1 sets fault and sets sector to 7.
- fault clears only while enable=0.
- Commutation, dir=0 ("+" leg active, "−" leg low-side on, third leg floating):
  - s0 A+B−, s1 A+C−, s2 B+C−, s3 B+A−, s4 C+A−, s5 C+B−.
- Commutation, dir=1: same sector table with + and − swapped.
- Per-leg request:
  - + leg: H=pwm_q, L=~pwm_q (complementary).
  - − leg: L=1.
  - Floating leg: none.
- Requests are all-none when enable=0, fault=1, or hall_valid=0.
- pwm_in, dir and sector are registered before the request logic.
- Leg FSM, per phase: IDLE, H_ON, L_ON, DEAD.
  - IDLE→H_ON/L_ON on request.
  - H_ON or L_ON → DEAD whenever its request drops.
  - DEAD counts DEADTIME cycles with both gates off, then goes to the requested on-state, or to IDLE if none.
  - Gate outputs are registered decodes of the state.
- Invariant: gate_h[i] & gate_l[i] is never 1.
- commutate pulses in the cycle sector takes a new valid value, including the first acquisition.
- No pulse on transition to 7.

## Timing
- Reset values: gate_h=0, gate_l=0, sector=7, commutate=0, fault=0; legs IDLE; debounce state cleared.
- Reset is asynchronous. Assertion mid-operation forces all gates off immediately, with no dead time required.
- pwm_in edge to gate change, no dead time pending: 2 clk cycles.
- Opposite switching on a leg: both-off for exactly DEADTIME cycles, then the new side asserts.
- Hall change to sector update: 2 (sync) + DEBOUNCE cycles. commutate is aligned with the sector update.
- Gates follow 1 cycle after sector update, subject to DEAD.
- A Hall glitch shorter than DEBOUNCE cycles is ignored.
- A request change during DEAD restarts nothing. The counter completes, then the current request is honoured.
- enable falling: on-legs enter DEAD then IDLE. All gates are 0 within 2 cycles.
- 0% or 100% PWM: no toggling; the + leg holds L or H respectively.

## Structure
- Package bldc_pkg holds:
  - sector encoding constants (including SECTOR_NONE=7);
  - the leg state enum;
  - the commutation-table function (sector, dir → per-leg {H,L,none} request).
- Sub-module deadtime_leg, instantiated ×3, parameterised by DEADTIME. It contains the leg FSM and counter, width $clog2(DEADTIME+1).
- The top level contains the sync/debounce, decode, fault, request logic and commutate.

## Test plan
- Reset asserted while gate_h[0]=1 → all gates 0 in the same cycle; sector=7; fault=0.
- enable=1, dir=0, pwm_in=1, hall=001 held → sector=0 and commutate pulse at 2+DEBOUNCE cycles; 1 cycle later gate_h=001, gate_l=010.
- Sector 0, pwm_in 1→0 with DEADTIME=16 → gate_h[0] falls at +2; gate_l[0] rises exactly 16 cycles later. Assert no leg ever has H&L.
- hall 001→011 glitch for 2 cycles, DEBOUNCE=4 → sector stays 0, no commutate. Full Hall rotation 001,011,010,110,100,101 → sectors 0..5, six pulses.
- hall=111 accepted → fault=1, sector=7, all gates 0 after dead-time. Valid Hall restored → fault stays 1. enable low then high → fault=0, drive resumes.
- dir=1, hall=001, pwm_in=1 → gate_h=010, gate_l=001 (B+, A−).

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared definitions for the six-step commutator: sector codes, leg FSM states,
// leg roles and the Hall-decode / commutation-table helpers.
package bldc_pkg;

    localparam logic [2:0] SECTOR_0    = 3'd0;
    localparam logic [2:0] SECTOR_1    = 3'd1;
    localparam logic [2:0] SECTOR_2    = 3'd2;
    localparam logic [2:0] SECTOR_3    = 3'd3;
    localparam logic [2:0] SECTOR_4    = 3'd4;
    localparam logic [2:0] SECTOR_5    = 3'd5;
    localparam logic [2:0] SECTOR_NONE = 3'd7;

    typedef logic [1:0] leg_state_t;
    localparam leg_state_t LEG_IDLE = 2'd0;
    localparam leg_state_t LEG_H_ON = 2'd1;
    localparam leg_state_t LEG_L_ON = 2'd2;
    localparam leg_state_t LEG_DEAD = 2'd3;

    localparam logic [1:0] ROLE_FLOAT = 2'd0;
    localparam logic [1:0] ROLE_PLUS  = 2'd1;
    localparam logic [1:0] ROLE_MINUS = 2'd2;

    function automatic logic [2:0] hall_decode(input logic [2:0] code);
        case (code)
            3'b001:  hall_decode = SECTOR_0;
            3'b011:  hall_decode = SECTOR_1;
            3'b010:  hall_decode = SECTOR_2;
            3'b110:  hall_decode = SECTOR_3;
            3'b100:  hall_decode = SECTOR_4;
            3'b101:  hall_decode = SECTOR_5;
            default: hall_decode = SECTOR_NONE;
        endcase
    endfunction

    // Per-leg roles packed {C,B,A}; reverse direction swaps the + and - legs.
    function automatic logic [5:0] comm_roles(input logic [2:0] sec, input logic rev);
        logic [5:0] fwd;
        case (sec)
            SECTOR_0: fwd = {ROLE_FLOAT, ROLE_MINUS, ROLE_PLUS};
            SECTOR_1: fwd = {ROLE_MINUS, ROLE_FLOAT, ROLE_PLUS};
            SECTOR_2: fwd = {ROLE_MINUS, ROLE_PLUS,  ROLE_FLOAT};
            SECTOR_3: fwd = {ROLE_FLOAT, ROLE_PLUS,  ROLE_MINUS};
            SECTOR_4: fwd = {ROLE_PLUS,  ROLE_FLOAT, ROLE_MINUS};
            SECTOR_5: fwd = {ROLE_PLUS,  ROLE_MINUS, ROLE_FLOAT};
            default:  fwd = {ROLE_FLOAT, ROLE_FLOAT, ROLE_FLOAT};
        endcase
        if (rev) begin
            comm_roles = {fwd[4], fwd[5], fwd[2], fwd[3], fwd[0], fwd[1]};
        end else begin
            comm_roles = fwd;
        end
    endfunction

endpackage

// File: rtl/bldc_commutator_leg.sv
// One inverter leg: guarantees DEADTIME both-off cycles between its two switches.
module deadtime_leg
    import bldc_pkg::*;
#(
    parameter int DEADTIME = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic req_h,
    input  logic req_l,
    output logic gate_h,
    output logic gate_l
);

    localparam int CW = $clog2(DEADTIME + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEADTIME - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    leg_state_t    state_r;
    leg_state_t    state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    // Next-state logic; a request change inside DEAD is only looked at when the gap ends.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            LEG_IDLE: begin
                if (req_h)      state_s = LEG_H_ON;
                else if (req_l) state_s = LEG_L_ON;
                else            state_s = LEG_IDLE;
            end
            LEG_H_ON: begin
                if (!req_h) begin
                    state_s = LEG_DEAD;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = LEG_H_ON;
                end
            end
            LEG_L_ON: begin
                if (!req_l) begin
                    state_s = LEG_DEAD;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = LEG_L_ON;
                end
            end
            LEG_DEAD: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (req_h)      state_s = LEG_H_ON;
                    else if (req_l) state_s = LEG_L_ON;
                    else            state_s = LEG_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = LEG_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered gate decode of the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= LEG_IDLE;
            cnt_r   <= CNT_ZERO;
            gate_h  <= 1'b0;
            gate_l  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            gate_h  <= (state_s == LEG_H_ON);
            gate_l  <= (state_s == LEG_L_ON);
        end
    end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step trapezoidal commutator: Hall sync/debounce, sector decode, fault,
// per-leg requests and three dead-time legs driving the inverter gates.
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int DEADTIME = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       dir,
    input  logic       pwm_in,
    input  logic [2:0] hall,
    output logic [2:0] gate_h,
    output logic [2:0] gate_l,
    output logic [2:0] sector,
    output logic       commutate,
    output logic       fault
);

    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam logic [DBW-1:0] DB_FULL = DBW'(DEBOUNCE);
    localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

    logic [2:0]     hall_meta_r;
    logic [2:0]     hall_sync_r;
    logic [2:0]     hall_cand_r;
    logic [DBW-1:0] db_cnt_r;
    logic [DBW-1:0] db_cnt_s;
    logic           accept_s;
    logic [2:0]     new_sector_s;
    logic           pwm_r;
    logic           dir_r;
    logic           drive_ok_s;
    logic [5:0]     roles_s;
    logic [2:0]     req_h_s;
    logic [2:0]     req_l_s;

    // Run length of identical synchronised samples; accept fires once when it reaches DEBOUNCE.
    always_comb begin
        if (hall_sync_r != hall_cand_r) begin
            db_cnt_s = DB_ONE;
        end else if (db_cnt_r != DB_FULL) begin
            db_cnt_s = db_cnt_r + DB_ONE;
        end else begin
            db_cnt_s = db_cnt_r;
        end
        accept_s     = (db_cnt_s == DB_FULL) &&
                       ((db_cnt_r != DB_FULL) || (hall_sync_r != hall_cand_r));
        new_sector_s = hall_decode(hall_sync_r);
    end

    // Hall synchroniser and debounce state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hall_meta_r <= 3'b000;
            hall_sync_r <= 3'b000;
            hall_cand_r <= 3'b000;
            db_cnt_r    <= {DBW{1'b0}};
        end else begin
            hall_meta_r <= hall;
            hall_sync_r <= hall_meta_r;
            hall_cand_r <= hall_sync_r;
            db_cnt_r    <= db_cnt_s;
        end
    end

    // Sector, commutate pulse and sticky fault; sector tracks Hall even while faulted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sector    <= SECTOR_NONE;
            commutate <= 1'b0;
            fault     <= 1'b0;
        end else begin
            if (accept_s) begin
                sector    <= new_sector_s;
                commutate <= (new_sector_s != SECTOR_NONE) && (new_sector_s != sector);
            end else begin
                commutate <= 1'b0;
            end
            if (!enable) begin
                fault <= 1'b0;
            end else if (accept_s && (new_sector_s == SECTOR_NONE)) begin
                fault <= 1'b1;
            end else begin
                fault <= fault;
            end
        end
    end

    // Input staging for the request logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_r <= 1'b0;
            dir_r <= 1'b0;
        end else begin
            pwm_r <= pwm_in;
            dir_r <= dir;
        end
    end

    // Per-leg H/L requests from the commutation table.
    always_comb begin
        drive_ok_s = enable && !fault && (sector != SECTOR_NONE);
        roles_s    = comm_roles(sector, dir_r);
        req_h_s    = 3'b000;
        req_l_s    = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (!drive_ok_s) begin
                req_h_s[i] = 1'b0;
                req_l_s[i] = 1'b0;
            end else if (roles_s[2*i +: 2] == ROLE_PLUS) begin
                req_h_s[i] = pwm_r;
                req_l_s[i] = !pwm_r;
            end else if (roles_s[2*i +: 2] == ROLE_MINUS) begin
                req_h_s[i] = 1'b0;
                req_l_s[i] = 1'b1;
            end else begin
                req_h_s[i] = 1'b0;
                req_l_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_leg
        deadtime_leg #(
            .DEADTIME(DEADTIME)
        ) u_leg (
            .clk    (clk),
            .reset  (reset),
            .req_h  (req_h_s[g]),
            .req_l  (req_l_s[g]),
            .gate_h (gate_h[g]),
            .gate_l (gate_l[g])
        );
    end

endmodule

// File: tb/tb_bldc_commutator.sv
// Bench for bldc_commutator: directed scenarios plus randomized stimulus, every
// cycle compared against a behavioural model built from the commutation rules.
module tb_bldc_commutator;

    localparam int DEADTIME = 16;
    localparam int DEBOUNCE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       dir;
    logic       pwm_in;
    logic [2:0] hall;
    logic [2:0] gate_h;
    logic [2:0] gate_l;
    logic [2:0] sector;
    logic       commutate;
    logic       fault;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;

    // model state
    int m_sync1, m_sync2;
    int dq[$];
    int m_sector;
    bit m_comm, m_fault, m_pwm_q, m_dir_q;
    int m_on[3];     // 0 off, 1 high side, 2 low side
    int m_dead[3];   // remaining both-off cycles

    int hall_to_sector[8] = '{7, 0, 2, 1, 4, 5, 3, 7};
    int plus_leg[6]       = '{0, 0, 1, 1, 2, 2};
    int minus_leg[6]      = '{1, 2, 2, 0, 0, 1};
    logic [2:0] hall_seq[6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    bldc_commutator #(
        .DEADTIME(DEADTIME),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .dir       (dir),
        .pwm_in    (pwm_in),
        .hall      (hall),
        .gate_h    (gate_h),
        .gate_l    (gate_l),
        .sector    (sector),
        .commutate (commutate),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_sync1 = 0;
        m_sync2 = 0;
        dq.delete();
        m_sector = 7;
        m_comm = 0;
        m_fault = 0;
        m_pwm_q = 0;
        m_dir_q = 0;
        for (int i = 0; i < 3; i++) begin
            m_on[i] = 0;
            m_dead[i] = 0;
        end
    endtask

    task automatic model_step();
        int req[3];
        int p, n, t, sample, run, s;
        for (int i = 0; i < 3; i++) req[i] = 0;
        if (enable && !m_fault && m_sector != 7) begin
            p = plus_leg[m_sector];
            n = minus_leg[m_sector];
            if (m_dir_q) begin
                t = p; p = n; n = t;
            end
            req[p] = m_pwm_q ? 1 : 2;
            req[n] = 2;
        end
        for (int i = 0; i < 3; i++) begin
            if (m_dead[i] > 0) begin
                m_dead[i]--;
                if (m_dead[i] == 0) m_on[i] = req[i];
            end else if (m_on[i] != 0 && req[i] != m_on[i]) begin
                m_on[i] = 0;
                m_dead[i] = DEADTIME;
            end else if (m_on[i] == 0) begin
                m_on[i] = req[i];
            end
        end
        sample = m_sync2;
        m_sync2 = m_sync1;
        m_sync1 = int'(hall);
        dq.push_back(sample);
        if (dq.size() > DEBOUNCE + 1) void'(dq.pop_front());
        run = 0;
        for (int k = dq.size() - 1; k >= 0; k--) begin
            if (dq[k] == sample) run++;
            else break;
        end
        m_comm = 0;
        if (run == DEBOUNCE) begin
            s = hall_to_sector[sample];
            if (s != 7) begin
                m_comm = (s != m_sector);
                m_sector = s;
            end else begin
                m_sector = 7;
                if (enable) m_fault = 1;
            end
        end
        if (!enable) m_fault = 0;
        m_pwm_q = pwm_in;
        m_dir_q = dir;
    endtask

    task automatic compare_model();
        logic [2:0] eh, el;
        for (int i = 0; i < 3; i++) begin
            eh[i] = (m_on[i] == 1);
            el[i] = (m_on[i] == 2);
        end
        check_value("outs", {21'd0, gate_h, gate_l, sector, commutate, fault},
                    {21'd0, eh, el, 3'(m_sector), m_comm, m_fault});
        check_value("hl_excl", {29'd0, gate_h & gate_l}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        #1;
        if (commutate === 1'b1) pulse_cnt++;
        compare_model();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r, idx, pwm_hold, hall_hold, glitch_left, en_hold;
        logic [2:0] base_code, glitch_code;
        logic [2:0] rot_code[6] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
        int rot_sec[6] = '{1, 2, 3, 4, 5, 0};

        reset = 1'b1; enable = 1'b0; dir = 1'b0; pwm_in = 1'b0; hall = 3'b000;
        model_reset();
        #2 reset = 1'b0;
        #1;
        check_value("rst_gates", {26'd0, gate_h, gate_l}, 32'd0);
        check_value("rst_sector", {29'd0, sector}, 32'd7);
        check_value("rst_flags", {30'd0, commutate, fault}, 32'd0);
        run_cycles(2);
        reset = 1'b1;
        run_cycles(8);

        // first acquisition
        enable = 1'b1; pwm_in = 1'b1; hall = 3'b001;
        n = 0;
        while (commutate !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_value("acq_latency", n, 2 + DEBOUNCE);
        check_value("acq_sector", {29'd0, sector}, 32'd0);
        step();
        check_value("acq_gate_h", {29'd0, gate_h}, 32'b001);
        check_value("acq_gate_l", {29'd0, gate_l}, 32'b010);

        // PWM falling edge with dead time on leg A
        pwm_in = 1'b0;
        step();
        check_value("pwm_hold_h", {31'd0, gate_h[0]}, 32'd1);
        step();
        check_value("pwm_fall_h", {31'd0, gate_h[0]}, 32'd0);
        check_value("pwm_fall_l", {31'd0, gate_l[0]}, 32'd0);
        n = 0;
        while (gate_l[0] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check_value("dead_gap", n, DEADTIME);
        pwm_in = 1'b1;
        run_cycles(DEADTIME + 4);
        check_value("pwm_back_h", {29'd0, gate_h}, 32'b001);

        // short glitch ignored
        pulse_cnt = 0;
        hall = 3'b011;
        run_cycles(DEBOUNCE - 2);
        hall = 3'b001;
        run_cycles(12);
        check_value("glitch_pulses", pulse_cnt, 0);
        check_value("glitch_sector", {29'd0, sector}, 32'd0);

        // full rotation
        pulse_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            hall = rot_code[k];
            run_cycles(DEBOUNCE + 4);
            check_value("rot_sector", {29'd0, sector}, rot_sec[k]);
        end
        check_value("rot_pulses", pulse_cnt, 6);

        // invalid Hall fault
        hall = 3'b111;
        run_cycles(12);
        check_value("flt_set", {31'd0, fault}, 32'd1);
        check_value("flt_sector", {29'd0, sector}, 32'd7);
        run_cycles(DEADTIME + 4);
        check_value("flt_gates", {26'd0, gate_h, gate_l}, 32'd0);
        hall = 3'b001;
        run_cycles(12);
        check_value("flt_sticky", {31'd0, fault}, 32'd1);
        enable = 1'b0;
        run_cycles(3);
        check_value("flt_clear", {31'd0, fault}, 32'd0);
        enable = 1'b1;
        run_cycles(DEADTIME + 6);
        check_value("resume_h", {29'd0, gate_h}, 32'b001);
        check_value("resume_l", {29'd0, gate_l}, 32'b010);

        // reverse direction
        dir = 1'b1;
        run_cycles(2 * DEADTIME + 8);
        check_value("rev_h", {29'd0, gate_h}, 32'b010);
        check_value("rev_l", {29'd0, gate_l}, 32'b001);

        // asynchronous reset while driving
        dir = 1'b0;
        run_cycles(2 * DEADTIME + 8);
        check_value("pre_reset_h", {31'd0, gate_h[0]}, 32'd1);
        reset = 1'b0;
        #1;
        check_value("async_rst_gates", {26'd0, gate_h, gate_l}, 32'd0);
        check_value("async_rst_sector", {29'd0, sector}, 32'd7);
        check_value("async_rst_fault", {31'd0, fault}, 32'd0);
        model_reset();
        step();
        reset = 1'b1;

        // randomized operation
        idx = 0; pwm_hold = 0; hall_hold = 0; glitch_left = 0; en_hold = 0;
        base_code = 3'b001; glitch_code = 3'b000;
        for (int c = 0; c < 4000; c++) begin
            if (pwm_hold == 0) begin
                pwm_in = 1'($urandom_range(0, 1));
                pwm_hold = $urandom_range(1, 40);
            end else begin
                pwm_hold--;
            end
            if (hall_hold == 0) begin
                r = $urandom_range(0, 99);
                if (r < 3) begin
                    base_code = (r == 0) ? 3'b000 : 3'b111;
                end else begin
                    idx = (idx + (r[0] ? 1 : 5)) % 6;
                    base_code = hall_seq[idx];
                end
                hall_hold = $urandom_range(8, 60);
                if ($urandom_range(0, 9) == 0) begin
                    glitch_left = $urandom_range(1, DEBOUNCE - 1);
                    glitch_code = 3'($urandom_range(0, 7));
                end
            end else begin
                hall_hold--;
            end
            hall = (glitch_left > 0) ? glitch_code : base_code;
            if (glitch_left > 0) glitch_left--;
            if (en_hold == 0) begin
                if ($urandom_range(0, 149) == 0) begin
                    enable = 1'b0;
                    en_hold = $urandom_range(1, 30);
                end else begin
                    enable = 1'b1;
                end
            end else begin
                en_hold--;
            end
            if ($urandom_range(0, 299) == 0) dir = ~dir;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
